// File: rtl/con_sched_pkg.sv
// Shared types for the conv bus scheduler: FSM state encoding, layer configuration, index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package con_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        TURN_OUT,
        DRIVE,
        TURN_IN
    } sched_state_e;

    typedef struct packed {
        int unsigned fm_w;
        int unsigned fm_h;
        int unsigned nb_ch;
        int unsigned load_beats;
    } sched_cfg_t;

    localparam sched_cfg_t DEFAULT_CFG = '{fm_w: 128, fm_h: 128, nb_ch: 64, load_beats: 9};

    // An extent of 1 still needs a 1-bit index.
    function automatic int unsigned idx_w(input int unsigned extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

endpackage

// File: rtl/coord_counter.sv
// Nested output-coordinate counter (x innermost, ch outermost), wrapping at the configured extents.
// Latency: coordinates update on the clock edge after adv_i; last_point_o is combinational.
// Backpressure: none; advances exactly once per cycle with adv_i high.
module coord_counter
    import con_sched_pkg::*;
#(
    parameter int unsigned FM_W  = DEFAULT_CFG.fm_w,
    parameter int unsigned FM_H  = DEFAULT_CFG.fm_h,
    parameter int unsigned NB_CH = DEFAULT_CFG.nb_ch
)(
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       clr_i,
    input  logic                       adv_i,
    output logic [idx_w(FM_W)-1:0]     x_o,
    output logic [idx_w(FM_H)-1:0]     y_o,
    output logic [idx_w(NB_CH)-1:0]    ch_o,
    output logic                       last_point_o
);

    localparam int unsigned XW = idx_w(FM_W);
    localparam int unsigned YW = idx_w(FM_H);
    localparam int unsigned CW = idx_w(NB_CH);
    localparam logic [XW-1:0] X_LAST  = XW'(FM_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(FM_H - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(NB_CH - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          x_wrap, y_wrap, ch_wrap;

    assign x_wrap  = (x_q == X_LAST);
    assign y_wrap  = (y_q == Y_LAST);
    assign ch_wrap = (ch_q == CH_LAST);

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        ch_d = ch_q;
        if (clr_i) begin
            x_d  = '0;
            y_d  = '0;
            ch_d = '0;
        end else if (adv_i) begin
            if (!x_wrap) begin
                x_d = x_q + XW'(1);
            end else begin
                x_d = '0;
                if (!y_wrap) begin
                    y_d = y_q + YW'(1);
                end else begin
                    y_d  = '0;
                    ch_d = ch_wrap ? '0 : ch_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            ch_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            ch_q <= ch_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign ch_o         = ch_q;
    assign last_point_o = x_wrap && y_wrap && ch_wrap;

endmodule

// File: rtl/con_bus_sched.sv
// Conv layer sequencer owning the shared con bus: load beats, wait for MAC, drive one tagged result; CON_SCHED_PERF_EN adds perf counters.
// Latency: LOAD_BEATS + 4 cycles per output point minimum (COMPUTE, TURN_OUT, DRIVE, TURN_IN).
// Backpressure: con_valid low stalls LOAD indefinitely; mac_done low holds COMPUTE.
module con_bus_sched
    import con_sched_pkg::*;
#(
    parameter int unsigned FEATURE_MAP_WIDTH  = DEFAULT_CFG.fm_w,
    parameter int unsigned FEATURE_MAP_HEIGHT = DEFAULT_CFG.fm_h,
    parameter int unsigned OUTPUT_NB_CHANNELS = DEFAULT_CFG.nb_ch,
    parameter int unsigned LOAD_BEATS         = DEFAULT_CFG.load_beats
)(
    input  logic                                   clk,
    input  logic                                   arst_n,
    input  logic                                   start,
    output logic                                   running,
    input  logic                                   con_valid,
    output logic                                   con_ready,
    output logic                                   beat_fire,
    output logic [idx_w(LOAD_BEATS)-1:0]           beat_idx,
    output logic                                   mac_clear,
    input  logic                                   mac_done,
    output logic                                   dut_driving_cons,
    output logic                                   output_valid,
    output logic [idx_w(FEATURE_MAP_WIDTH)-1:0]    output_x,
    output logic [idx_w(FEATURE_MAP_HEIGHT)-1:0]   output_y,
    output logic [idx_w(OUTPUT_NB_CHANNELS)-1:0]   output_ch
`ifdef CON_SCHED_PERF_EN
    ,
    output logic [31:0]                            perf_in_beats,
    output logic [31:0]                            perf_stall_cycles
`endif
);

    localparam sched_cfg_t CFG = '{fm_w: FEATURE_MAP_WIDTH, fm_h: FEATURE_MAP_HEIGHT,
                                   nb_ch: OUTPUT_NB_CHANNELS, load_beats: LOAD_BEATS};
    localparam int unsigned BW = idx_w(CFG.load_beats);
    localparam int unsigned XW = idx_w(CFG.fm_w);
    localparam int unsigned YW = idx_w(CFG.fm_h);
    localparam int unsigned CW = idx_w(CFG.nb_ch);
    localparam logic [BW-1:0] LAST_BEAT = BW'(CFG.load_beats - 1);

    sched_state_e  state_q;
    logic [BW-1:0] beat_q;
    logic          running_q, drive_q, ovld_q;
    logic [XW-1:0] out_x_q, cur_x;
    logic [YW-1:0] out_y_q, cur_y;
    logic [CW-1:0] out_ch_q, cur_ch;
    logic          start_acc, last_point;

    assign start_acc = (state_q == IDLE) && start;
    assign con_ready = (state_q == LOAD);
    assign beat_fire = con_ready && con_valid;
    assign beat_idx  = beat_q;
    assign mac_clear = beat_fire && (beat_q == '0);

    coord_counter #(
        .FM_W  (CFG.fm_w),
        .FM_H  (CFG.fm_h),
        .NB_CH (CFG.nb_ch)
    ) u_coord (
        .clk          (clk),
        .arst_n       (arst_n),
        .clr_i        (start_acc),
        .adv_i        (state_q == TURN_IN),
        .x_o          (cur_x),
        .y_o          (cur_y),
        .ch_o         (cur_ch),
        .last_point_o (last_point)
    );

    // Bus ownership is registered so an async reset releases the bus immediately.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            running_q <= 1'b0;
            drive_q   <= 1'b0;
            ovld_q    <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_ch_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        running_q <= 1'b1;
                        beat_q    <= '0;
                    end
                end
                LOAD: begin
                    if (con_valid) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= COMPUTE;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (mac_done) begin
                        state_q <= TURN_OUT;
                        drive_q <= 1'b1;
                    end
                end
                TURN_OUT: begin
                    state_q  <= DRIVE;
                    ovld_q   <= 1'b1;
                    out_x_q  <= cur_x;
                    out_y_q  <= cur_y;
                    out_ch_q <= cur_ch;
                end
                DRIVE: begin
                    state_q <= TURN_IN;
                    drive_q <= 1'b0;
                    ovld_q  <= 1'b0;
                end
                TURN_IN: begin
                    if (last_point) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign running          = running_q;
    assign dut_driving_cons = drive_q;
    assign output_valid     = ovld_q;
    assign output_x         = out_x_q;
    assign output_y         = out_y_q;
    assign output_ch        = out_ch_q;

`ifdef CON_SCHED_PERF_EN
    logic [31:0] perf_in_q, perf_stall_q;
    logic        stall;

    assign stall = ((state_q == LOAD) && !con_valid) || ((state_q == COMPUTE) && !mac_done);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_in_q    <= '0;
            perf_stall_q <= '0;
        end else if (start_acc) begin
            perf_in_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (beat_fire && (perf_in_q != '1)) begin
                perf_in_q <= perf_in_q + 32'd1;
            end
            if (stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_in_beats     = perf_in_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_con_bus_sched.sv
// Scoreboard bench for con_bus_sched with a 2x2x2 layer and 3 load beats per point.
module tb_con_bus_sched;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int CH = 2;
    localparam int LB = 3;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start = 1'b0;
    logic       con_valid = 1'b0;
    logic       mac_done = 1'b0;
    logic       running, con_ready, beat_fire, mac_clear, dut_driving_cons, output_valid;
    logic [1:0] beat_idx;
    logic [0:0] output_x, output_y, output_ch;
`ifdef CON_SCHED_PERF_EN
    logic [31:0] perf_in_beats, perf_stall_cycles;
`endif

    typedef struct {
        int x;
        int y;
        int ch;
    } coord_t;

    int     checks = 0;
    int     failures = 0;
    coord_t sb[$];
    int     load_entries[$];
    int     cyc = 0;
    int     nrun = 0;
    int     nbeat = 0;
    int     nclear = 0;
    int     turn_cnt = 0;
    logic   prev_ready = 1'b0;

    con_bus_sched #(
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .OUTPUT_NB_CHANNELS (CH),
        .LOAD_BEATS         (LB)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .start            (start),
        .running          (running),
        .con_valid        (con_valid),
        .con_ready        (con_ready),
        .beat_fire        (beat_fire),
        .beat_idx         (beat_idx),
        .mac_clear        (mac_clear),
        .mac_done         (mac_done),
        .dut_driving_cons (dut_driving_cons),
        .output_valid     (output_valid),
        .output_x         (output_x),
        .output_y         (output_y),
        .output_ch        (output_ch)
`ifdef CON_SCHED_PERF_EN
        ,
        .perf_in_beats     (perf_in_beats),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pushes the first n points in x-inner, ch-outer order, then pulses start.
    task automatic start_layer(input int n);
        int k = 0;
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    if (k < n) sb.push_back('{x: x, y: y, ch: c});
                    k++;
                end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_to_idle(input int budget, input string name);
        int n = 0;
        while (running && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, int'(running), 0);
    endtask

    function automatic int entry_gap(input int i);
        if (load_entries.size() > i) return load_entries[i] - load_entries[i-1];
        return -1;
    endfunction

    always @(negedge clk) begin : monitor
        coord_t e;
        cyc++;
        if (running)   nrun++;
        if (beat_fire) nbeat++;
        if (mac_clear) nclear++;
        if (con_ready && !prev_ready) load_entries.push_back(cyc);
        prev_ready = con_ready;
        chk("bus_exclusive", int'(dut_driving_cons && con_ready), 0);
        if (output_valid) begin
            chk("ovld_owns_bus", int'(dut_driving_cons), 1);
            chk("turnaround_cycles", turn_cnt, 1);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got (%0d,%0d,%0d), required no output",
                         output_x, output_y, output_ch);
            end else begin
                e = sb.pop_front();
                chk("out_x", int'(output_x), e.x);
                chk("out_y", int'(output_y), e.y);
                chk("out_ch", int'(output_ch), e.ch);
            end
            turn_cnt = 0;
        end else if (dut_driving_cons) begin
            turn_cnt++;
        end else begin
            turn_cnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        arst_n = 1'b1;
        #2 arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_running", int'(running), 0);
        chk("rst_con_ready", int'(con_ready), 0);
        chk("rst_beat_fire", int'(beat_fire), 0);
        chk("rst_mac_clear", int'(mac_clear), 0);
        chk("rst_driving", int'(dut_driving_cons), 0);
        chk("rst_ovld", int'(output_valid), 0);
        chk("rst_beat_idx", int'(beat_idx), 0);
        chk("rst_xyz", int'({output_x, output_y, output_ch}), 0);
`ifdef CON_SCHED_PERF_EN
        chk("rst_perf_in", int'(perf_in_beats), 0);
        chk("rst_perf_stall", int'(perf_stall_cycles), 0);
`endif
        arst_n = 1'b1;

        // Inputs other than start are ignored in IDLE.
        con_valid = 1'b1;
        mac_done  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_con_ready", int'(con_ready), 0);
            chk("idle_beat_fire", int'(beat_fire), 0);
            chk("idle_running", int'(running), 0);
            @(posedge clk); #1;
        end

        // Full layer, no stalls.
        nrun = 0; nbeat = 0; nclear = 0;
        load_entries.delete();
        start_layer(8);
        run_to_idle(200, "full_run");
        chk("full_running_cycles", nrun, 56);
        chk("full_beats", nbeat, 24);
        chk("full_mac_clears", nclear, 8);
        chk("full_sb_empty", sb.size(), 0);
        chk("full_points", load_entries.size(), 8);
        for (int i = 1; i < 8; i++) chk("full_point_cycles", entry_gap(i), 7);

        // con_valid low for 5 cycles after beat 0.
        load_entries.delete();
        start_layer(8);
        @(posedge clk); #1 con_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_beat_idx", int'(beat_idx), 1);
            chk("stall_no_fire", int'(beat_fire), 0);
            @(posedge clk);
        end
        #1 con_valid = 1'b1;
        run_to_idle(300, "stall_run");
        chk("stall_point_cycles", entry_gap(1), 12);
        chk("after_stall_point_cycles", entry_gap(2), 7);
        chk("stall_sb_empty", sb.size(), 0);

        // start and mac_done during LOAD must be ignored.
        con_valid = 1'b0;
        mac_done  = 1'b0;
        start_layer(8);
        start    = 1'b1;
        mac_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_con_ready", int'(con_ready), 1);
            chk("spur_beat_idx", int'(beat_idx), 0);
            chk("spur_driving", int'(dut_driving_cons), 0);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        con_valid = 1'b1;
        run_to_idle(300, "spur_run");
        chk("spur_sb_empty", sb.size(), 0);

        // Random handshakes; the monitor checks exclusivity and turnaround.
        start_layer(8);
        n = 0;
        while (running && n < 3000) begin
            @(posedge clk); #1;
            con_valid = 1'($urandom_range(0, 1));
            mac_done  = 1'($urandom_range(0, 1));
            n++;
        end
        chk("rand_timeout", int'(running), 0);
        chk("rand_sb_empty", sb.size(), 0);
        con_valid = 1'b1;
        mac_done  = 1'b1;

        // Reset while the first result is on the bus.
        start_layer(1);
        n = 0;
        while (!output_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_drive", int'(output_valid), 1);
        #1 arst_n = 1'b0;
        #1;
        chk("midrst_driving", int'(dut_driving_cons), 0);
        chk("midrst_ovld", int'(output_valid), 0);
        chk("midrst_running", int'(running), 0);
        chk("midrst_con_ready", int'(con_ready), 0);
        chk("midrst_xyz", int'({output_x, output_y, output_ch}), 0);
        @(negedge clk); #1 arst_n = 1'b1;
        chk("midrst_sb_empty", sb.size(), 0);
        repeat (4) @(negedge clk);
        chk("midrst_idle", int'(running), 0);
        start_layer(8);
        run_to_idle(200, "restart_run");
        chk("restart_sb_empty", sb.size(), 0);

`ifdef CON_SCHED_PERF_EN
        // mac_done held off for 4 COMPUTE cycles each point.
        mac_done = 1'b0;
        start_layer(8);
        for (int p = 0; p < 8; p++) begin
            n = 0;
            while (!(beat_fire && beat_idx == 2'd2) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("perf_last_beat_seen", int'(beat_fire && beat_idx == 2'd2), 1);
            @(posedge clk);
            repeat (4) @(posedge clk);
            #1 mac_done = 1'b1;
            @(posedge clk); #1 mac_done = 1'b0;
        end
        run_to_idle(300, "perf_run");
        chk("perf_in_beats", int'(perf_in_beats), 24);
        chk("perf_stall_cycles", int'(perf_stall_cycles), 32);
        chk("perf_sb_empty", sb.size(), 0);
        mac_done = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/con_bus_sched.md
Name: con_bus_sched

Overview:
- Top-level sequencer of the conv accelerator. It owns the shared bidirectional con_1..con_3 bus.
- Per output point it does the following in order:
  - accepts LOAD_BEATS input beats over the con valid/ready handshake;
  - waits for the MAC datapath to finish;
  - turns the bus around, drives one result beat tagged with x/y/ch, and turns the bus back.
- Iterates over all output coordinates after a start pulse.

Parameters:
- FEATURE_MAP_WIDTH, 128: output x extent.
- FEATURE_MAP_HEIGHT, 128: output y extent.
- OUTPUT_NB_CHANNELS, 64: output channel extent.
- LOAD_BEATS, 9: con handshakes per output point (>=1).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a full layer; sampled only in IDLE.
- running  out  1  high from the cycle after accepted start until return to IDLE.
- con_valid  in  1  testbench input beat valid.
- con_ready  out  1  scheduler accepts an input beat.
- beat_fire  out  1  to datapath: capture con_1..3 this cycle (con_valid && con_ready).
- beat_idx  out  $clog2(LOAD_BEATS)  index of the captured beat.
- mac_clear  out  1  to datapath: clear accumulator; coincides with beat_idx==0 fire.
- mac_done  in  1  datapath result ready; level, sampled only in COMPUTE.
- dut_driving_cons  out  1  DUT owns the con bus (testbench tri-states).
- output_valid  out  1  result beat present on con bus.
- output_x  out  $clog2(FEATURE_MAP_WIDTH)  x of the result beat.
- output_y  out  $clog2(FEATURE_MAP_HEIGHT)  y of the result beat.
- output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  channel of the result beat.

Behaviour:
- Reset is asynchronous: on arst_n low, state=IDLE and all counters=0.
- Reset values: running, con_ready, beat_fire, mac_clear, dut_driving_cons and output_valid are 0; beat_idx and output_x/y/ch are 0.
- All outputs are registered except con_ready, beat_fire, beat_idx and mac_clear, which decode from the state register.
- FSM states and outputs:
  - IDLE: running=0. start=1 -> LOAD next cycle; counters x=y=ch=beat=0.
  - LOAD: con_ready=1. On con_valid, beat_fire=1 and beat++. Firing the last beat (LOAD_BEATS-1) -> COMPUTE with beat=0. con_valid low stalls indefinitely.
  - COMPUTE: con_ready=0. mac_done=1 -> TURN_OUT.
  - TURN_OUT: one cycle. dut_driving_cons=1, output_valid=0 (bus turnaround). -> DRIVE.
  - DRIVE: one cycle. dut_driving_cons=1, output_valid=1, output_x/y/ch = current counters. -> TURN_IN.
  - TURN_IN: one cycle. dut_driving_cons=0, con_ready=0. Advance coordinates:
    - x++; x wrap -> y++; y wrap -> ch++.
    - If the point was the last (x=W-1, y=H-1, ch=CH-1) -> IDLE, else LOAD.
- Loop order: x innermost, then y, then ch outermost.
- Minimum cycles per point = LOAD_BEATS + 1 (COMPUTE, if mac_done is already high) + 3.
- dut_driving_cons is never 1 in the same cycle as con_ready=1. The bus always has at least one turnaround cycle in each direction.
- Ignored inputs:
  - start outside IDLE is ignored.
  - con_valid outside LOAD is ignored; no beat_fire.
  - mac_done outside COMPUTE is ignored.
- LOAD_BEATS=1: mac_clear and the last-beat transition fire on the same beat.
- Counters wrap at the parameter extent, not at the power of two.
- Reset mid-DRIVE: dut_driving_cons drops asynchronously. No partial output_valid is reissued after reset.
- running falls in the cycle after TURN_IN of the last point.

Optional Feature:
- Macro: CON_SCHED_PERF_EN.
- When defined, two extra outputs are added:
  - perf_in_beats (32b): counts beat_fire.
  - perf_stall_cycles (32b): counts cycles in LOAD with con_valid=0 plus cycles in COMPUTE with mac_done=0.
- Both counters clear on arst_n and on accepted start, and saturate at all-ones.
- When undefined: no ports and no logic are added.

Decomposition:
- Package con_sched_pkg holds:
  - the state enum (IDLE, LOAD, COMPUTE, TURN_OUT, DRIVE, TURN_IN);
  - the width localparams derived via $clog2 from the config struct.
- One natural sub-module: coord_counter, the nested x/y/ch counter with an advance input and a last_point output.
- The FSM stays in con_bus_sched.

Test Plan:
- Test configuration: W=2, H=2, CH=2, LOAD_BEATS=3.
- Full run, con_valid always 1, mac_done always 1:
  - 8 DRIVE beats with (x,y,ch) in order (0,0,0), (1,0,0), (0,1,0), (1,1,0), (0,0,1) … (1,1,1);
  - 7 cycles per point;
  - running high for exactly 56 cycles.
- Input stall: con_valid low for 5 cycles after beat 1 -> beat_idx holds at 1, no beat_fire, and the point takes 12 cycles.
- Bus exclusivity: random con_valid/mac_done -> the assertion !(dut_driving_cons && con_ready) holds every cycle, and each output_valid is preceded by exactly one dut_driving_cons cycle without output_valid.
- Spurious inputs: start pulsed during LOAD, and mac_done high during LOAD -> no state change and coordinates unaffected.
- Reset mid-DRIVE: arst_n low for 1 cycle -> all outputs 0 immediately and running=0. A new start restarts at (0,0,0).
- Performance counters (CON_SCHED_PERF_EN defined): full run with mac_done delayed 4 cycles per point -> perf_in_beats=24 and perf_stall_cycles=32.
